// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Pops scan-code bytes from the ps2_keyboard receiver FIFO and
//               decodes PS/2 set-2 make / break (F0) / extended (E0)
//               sequences into key events. Tracks the current key, its ASCII
//               value and a press counter, and drives six active-low
//               seven-segment digits ({a,b,c,d,e,f,g,dp}, dp always off).
// Revision    : 1.0 - initial release
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_data[7:0]       FIFO head byte
//   ps2_ready           FIFO non-empty
//   ps2_overflow        FIFO overflow flag (sets sticky err)
//   nextdata_n          active-low one-cycle pop strobe
//   key_code/key_ext    last make code and its E0 qualifier
//   key_ascii           ASCII of key_code (0x00 if unmapped or extended)
//   key_down            key_code is currently held
//   press_cnt           count of new presses (wraps)
//   event_valid/_break  one-cycle event pulse, break qualifier
//   err                 sticky overflow seen
//   seg_*               active-low seven-segment digits
//
// Configuration macro:
//   KBD_SHIFT_EN        track left/right shift (0x12/0x59) for upper-case
//                       letters; shift codes produce no key events.
// ============================================================================
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             event_valid,
  output logic             event_break,
  output logic             err,
  output logic [7:0]       seg_code_lo,
  output logic [7:0]       seg_code_hi,
  output logic [7:0]       seg_ascii_lo,
  output logic [7:0]       seg_ascii_hi,
  output logic [7:0]       seg_cnt_lo,
  output logic [7:0]       seg_cnt_hi
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_byte;
  logic             r_nextdata_n;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic [7:0]       r_key_ascii;
  logic             r_key_down;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_event_valid;
  logic             r_event_break;
  logic             r_err;
  logic             r_brk_pend;
  logic             r_ext_pend;

  logic             w_same;
  logic             w_upper;
  logic [7:0]       w_cnt8;

`ifdef KBD_SHIFT_EN
  logic             r_shift_held;
  logic             w_is_shift;
  assign w_is_shift = (r_byte == 8'h12) || (r_byte == 8'h59);
  assign w_upper    = r_shift_held;
`else
  assign w_upper    = 1'b0;
`endif

  // Incoming code matches the held key, including its E0 qualifier.
  assign w_same = (r_byte == r_key_code) && (r_ext_pend == r_key_ext);

  // Set-2 scan code to ASCII; extended codes are filtered by the caller.
  function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    if (upper && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

  // Hex digit to active-low {a,b,c,d,e,f,g,dp}.
  function automatic logic [7:0] f_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03; 4'h1: s = 8'h9F; 4'h2: s = 8'h25; 4'h3: s = 8'h0D;
      4'h4: s = 8'h99; 4'h5: s = 8'h49; 4'h6: s = 8'h41; 4'h7: s = 8'h1F;
      4'h8: s = 8'h01; 4'h9: s = 8'h09; 4'hA: s = 8'h11; 4'hB: s = 8'hC1;
      4'hC: s = 8'h63; 4'hD: s = 8'h85; 4'hE: s = 8'h61; default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_byte        <= 8'h00;
      r_nextdata_n  <= 1'b1;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_ascii   <= 8'h00;
      r_key_down    <= 1'b0;
      r_press_cnt   <= '0;
      r_event_valid <= 1'b0;
      r_event_break <= 1'b0;
      r_err         <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_ext_pend    <= 1'b0;
`ifdef KBD_SHIFT_EN
      r_shift_held  <= 1'b0;
`endif
    end else begin
      r_event_valid <= 1'b0;
      r_event_break <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ps2_ready) begin
            r_byte       <= ps2_data;
            r_nextdata_n <= 1'b0;
            r_state      <= S_ACK;
          end
        end
        S_ACK: begin
          r_nextdata_n <= 1'b1;
          r_state      <= S_IDLE;
          if (r_byte == 8'hF0) begin
            r_brk_pend <= 1'b1;
          end else if (r_byte == 8'hE0) begin
            r_ext_pend <= 1'b1;
`ifdef KBD_SHIFT_EN
          end else if (w_is_shift) begin
            // Shift keys only steer the letter case; no key event.
            r_shift_held <= ~r_brk_pend;
            r_brk_pend   <= 1'b0;
            r_ext_pend   <= 1'b0;
`endif
          end else if (r_brk_pend) begin
            r_event_valid <= 1'b1;
            r_event_break <= 1'b1;
            if (w_same) r_key_down <= 1'b0;
            r_brk_pend    <= 1'b0;
            r_ext_pend    <= 1'b0;
          end else if (r_key_down && w_same) begin
            // Typematic repeat: event only, state untouched.
            r_event_valid <= 1'b1;
          end else begin
            r_key_code    <= r_byte;
            r_key_ext     <= r_ext_pend;
            r_key_down    <= 1'b1;
            r_press_cnt   <= r_press_cnt + c_cnt_one;
            r_key_ascii   <= r_ext_pend ? 8'h00 : f_ascii(r_byte, w_upper);
            r_event_valid <= 1'b1;
            r_ext_pend    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed after the decode so that overflow wins over a same-cycle
      // F0/E0 decode and the pending flags always end up cleared.
      if (ps2_overflow) begin
        r_err      <= 1'b1;
        r_brk_pend <= 1'b0;
        r_ext_pend <= 1'b0;
      end
    end
  end

  generate
    if (CNT_W >= 8) begin : g_cnt_wide
      assign w_cnt8 = r_press_cnt[7:0];
    end else begin : g_cnt_narrow
      assign w_cnt8 = {{(8-CNT_W){1'b0}}, r_press_cnt};
    end
  endgenerate

  assign nextdata_n   = r_nextdata_n;
  assign key_code     = r_key_code;
  assign key_ext      = r_key_ext;
  assign key_ascii    = r_key_ascii;
  assign key_down     = r_key_down;
  assign press_cnt    = r_press_cnt;
  assign event_valid  = r_event_valid;
  assign event_break  = r_event_break;
  assign err          = r_err;

  assign seg_code_lo  = r_key_down ? f_seg(r_key_code[3:0])  : 8'hFF;
  assign seg_code_hi  = r_key_down ? f_seg(r_key_code[7:4])  : 8'hFF;
  assign seg_ascii_lo = r_key_down ? f_seg(r_key_ascii[3:0]) : 8'hFF;
  assign seg_ascii_hi = r_key_down ? f_seg(r_key_ascii[7:4]) : 8'hFF;
  assign seg_cnt_lo   = f_seg(w_cnt8[3:0]);
  assign seg_cnt_hi   = f_seg(w_cnt8[7:4]);

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder. Bytes are
//               offered through the ready/nextdata_n handshake; outputs are
//               sampled on the falling clock edge and compared against
//               hand-computed values with immediate assertions.
// Revision    : 1.0 - initial release
// Configuration macro: KBD_SHIFT_EN selects the shift-scenario expectations.
// ============================================================================
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_down;
  logic [7:0] press_cnt;
  logic       event_valid;
  logic       event_break;
  logic       err;
  logic [7:0] seg_code_lo, seg_code_hi, seg_ascii_lo, seg_ascii_hi;
  logic [7:0] seg_cnt_lo, seg_cnt_hi;

  int n_cmp  = 0;
  int n_fail = 0;
  int ev_total  = 0;
  int brk_total = 0;
  int ev0, brk0;

  ps2_key_decoder #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_ascii    (key_ascii),
    .key_down     (key_down),
    .press_cnt    (press_cnt),
    .event_valid  (event_valid),
    .event_break  (event_break),
    .err          (err),
    .seg_code_lo  (seg_code_lo),
    .seg_code_hi  (seg_code_hi),
    .seg_ascii_lo (seg_ascii_lo),
    .seg_ascii_hi (seg_ascii_hi),
    .seg_cnt_lo   (seg_cnt_lo),
    .seg_cnt_hi   (seg_cnt_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event pulses are counted on the rising edge (pre-update value), so a
  // pulse is registered one edge after the decode that produced it.
  always @(posedge clk) begin
    if (event_valid === 1'b1) begin
      ev_total = ev_total + 1;
      if (event_break === 1'b1) brk_total = brk_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ps2_ready = 1'b0; ps2_overflow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one byte; checks the pop strobe and the resulting event pulse.
  task automatic send_byte(input logic [7:0] b, input logic exp_ev,
                           input logic exp_brk, input logic ovf_in_ack);
    @(negedge clk);
    ps2_data = b; ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
    chk("pop_low", nextdata_n, 1'b0);
    if (ovf_in_ack) ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    chk("pop_high", nextdata_n, 1'b1);
    chk("ev_valid", event_valid, exp_ev);
    if (exp_ev) chk("ev_break", event_break, exp_brk);
  endtask

  initial begin
    rst = 1'b1; ps2_data = 8'h00; ps2_ready = 1'b0; ps2_overflow = 1'b0;
    do_reset();

    // ---- reset state
    chk("rst_nd", nextdata_n, 1'b1);
    chk("rst_code", key_code, 8'h00);
    chk("rst_ext", key_ext, 1'b0);
    chk("rst_ascii", key_ascii, 8'h00);
    chk("rst_down", key_down, 1'b0);
    chk("rst_cnt", press_cnt, 8'h00);
    chk("rst_ev", event_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_seg_code", {seg_code_hi, seg_code_lo}, 16'hFFFF);
    chk("rst_seg_ascii", {seg_ascii_hi, seg_ascii_lo}, 16'hFFFF);
    chk("rst_seg_cnt", {seg_cnt_hi, seg_cnt_lo}, 16'h0303);

    // ---- press and release q
    send_byte(8'h15, 1'b1, 1'b0, 1'b0);
    chk("q_code", key_code, 8'h15);
    chk("q_ascii", key_ascii, 8'h71);
    chk("q_down", key_down, 1'b1);
    chk("q_cnt", press_cnt, 8'h01);
    chk("q_seg_code", {seg_code_hi, seg_code_lo}, 16'h9F49);
    chk("q_seg_ascii", {seg_ascii_hi, seg_ascii_lo}, 16'h1F9F);
    chk("q_seg_cnt", {seg_cnt_hi, seg_cnt_lo}, 16'h039F);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h15, 1'b1, 1'b1, 1'b0);
    chk("qr_down", key_down, 1'b0);
    chk("qr_cnt", press_cnt, 8'h01);
    chk("qr_seg_code", {seg_code_hi, seg_code_lo}, 16'hFFFF);
    chk("qr_seg_ascii", {seg_ascii_hi, seg_ascii_lo}, 16'hFFFF);

    // ---- handshake with ready held high over three 1C bytes (typematic)
    do_reset();
    ev0 = ev_total; brk0 = brk_total;
    @(negedge clk);
    ps2_data = 8'h1C; ps2_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("hs_nd%0d", k), nextdata_n, (k % 2 == 0) ? 1'b0 : 1'b1);
      if (k == 5) ps2_ready = 1'b0;
    end
    chk("rep_cnt3", press_cnt, 8'h01);
    chk("rep_down3", key_down, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("rep_events", ev_total - ev0, 4);
    chk("rep_breaks", brk_total - brk0, 1);
    chk("rep_cnt", press_cnt, 8'h01);
    chk("rep_ascii", key_ascii, 8'h61);
    chk("rep_down", key_down, 1'b0);

    // ---- extended key
    do_reset();
    send_byte(8'hE0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b1, 1'b0, 1'b0);
    chk("ext_ext", key_ext, 1'b1);
    chk("ext_code", key_code, 8'h75);
    chk("ext_ascii", key_ascii, 8'h00);
    chk("ext_seg_ascii", {seg_ascii_hi, seg_ascii_lo}, 16'h0303);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b1, 1'b1, 1'b0);
    chk("ext_down", key_down, 1'b0);
    chk("ext_ext2", key_ext, 1'b1);

    // ---- counter wrap after 256 distinct presses
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte((i % 2 == 1) ? 8'h32 : 8'h1C, 1'b1, 1'b0, 1'b0);
      if (i == 254) chk("wrap_ff", press_cnt, 8'hFF);
    end
    chk("wrap_cnt", press_cnt, 8'h00);
    chk("wrap_code", key_code, 8'h32);
    chk("wrap_seg_cnt", {seg_cnt_hi, seg_cnt_lo}, 16'h0303);

    // ---- reset after a pending F0 discards it
    send_byte(8'h15, 1'b1, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_byte(8'h15, 1'b1, 1'b0, 1'b0);
    chk("rstf0_cnt", press_cnt, 8'h01);
    chk("rstf0_down", key_down, 1'b1);

    // ---- overflow: sticky err, clears pending flags
    do_reset();
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); ps2_overflow = 1'b1;
    @(negedge clk); ps2_overflow = 1'b0;
    chk("ovf_err", err, 1'b1);
    send_byte(8'h15, 1'b1, 1'b0, 1'b0);
    chk("ovf_down", key_down, 1'b1);
    chk("ovf_cnt", press_cnt, 8'h01);
    send_byte(8'hE0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h75, 1'b1, 1'b0, 1'b0);
    chk("ovfack_ext", key_ext, 1'b0);
    chk("ovfack_code", key_code, 8'h75);
    chk("ovfack_cnt", press_cnt, 8'h02);
    chk("ovf_err_sticky", err, 1'b1);
    do_reset();
    chk("ovf_err_rst", err, 1'b0);

    // ---- shift
    do_reset();
`ifdef KBD_SHIFT_EN
    send_byte(8'h12, 1'b0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0, 1'b0);
    chk("shift_ascii", key_ascii, 8'h41);
    chk("shift_cnt", press_cnt, 8'h01);
`else
    send_byte(8'h12, 1'b1, 1'b0, 1'b0);
    chk("noshift_ascii12", key_ascii, 8'h00);
    send_byte(8'h1C, 1'b1, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 1'b1, 1'b0);
    chk("noshift_ascii", key_ascii, 8'h61);
    chk("noshift_cnt", press_cnt, 8'h02);
`endif
    chk("shift_down", key_down, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream consumer of the `ps2_keyboard` receiver FIFO. Pops scan-code bytes through the `ready`/`nextdata_n` handshake and decodes PS/2 set-2 make, break (F0) and extended (E0) sequences into key events. Also tracks the current key, its ASCII value and a press counter, and drives six active-low seven-segment digits for the board top.

## Interface
Parameters:
- `CNT_W`, default 8: width of the press counter. The two count digits show its low byte.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `ps2_data`, in, 8: FIFO head byte from `ps2_keyboard`.
- `ps2_ready`, in, 1: FIFO non-empty.
- `ps2_overflow`, in, 1: FIFO overflow flag.
- `nextdata_n`, out, 1: active-low pop strobe to `ps2_keyboard`.
- `key_code`, out, 8: last make scan code, without the E0 prefix.
- `key_ext`, out, 1: last make code was E0-prefixed.
- `key_ascii`, out, 8: ASCII value of `key_code`. 0x00 if the code is unmapped.
- `key_down`, out, 1: `key_code` is currently held.
- `press_cnt`, out, `CNT_W`: count of new presses.
- `event_valid`, out, 1: one-cycle pulse per decoded make, repeat or break.
- `event_break`, out, 1: qualifies `event_valid`. 1 = break event.
- `err`, out, 1: sticky overflow seen.
- `seg_code_lo`, `seg_code_hi`, `seg_ascii_lo`, `seg_ascii_hi`, `seg_cnt_lo`, `seg_cnt_hi`, out, 8 each: active-low segments.

## Operation
FSM with two states: IDLE and ACK.
- **IDLE:** on `ps2_ready`=1:
  - latch `ps2_data` into `byte_r`;
  - drive `nextdata_n` to 0;
  - go to ACK.
  Otherwise stay in IDLE.
- **ACK:**
  - drive `nextdata_n` back to 1;
  - decode `byte_r`;
  - return to IDLE.
  IDLE does not sample `ps2_ready` during ACK, so the FIFO pointer has settled before the next sample.

Decode of `byte_r`:
- **0xF0:** set `brk_pend`. No event.
- **0xE0:** set `ext_pend`. No event.
- **Other code with `brk_pend`=1 (break):**
  - pulse `event_valid` with `event_break`=1;
  - if the code equals `key_code` and `ext_pend` equals `key_ext`, clear `key_down`; otherwise leave `key_down` unchanged;
  - clear both pending flags.
- **Other code, `brk_pend`=0, `key_down`=1, same code and ext (typematic repeat):** pulse `event_valid` with `event_break`=0. No other state changes.
- **Other code, otherwise (new press):**
  - load `key_code` and `key_ext`;
  - set `key_down`=1;
  - `press_cnt` += 1, wrapping from all-ones to 0;
  - update `key_ascii`;
  - pulse `event_valid`;
  - clear `ext_pend`.

ASCII map (non-extended codes only):
- a–z → 0x61–0x7A (set-2 codes, e.g. 0x1C→'a', 0x15→'q');
- 0–9 row (0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46) → 0x30–0x39;
- 0x29 → 0x20; 0x5A → 0x0D;
- everything else, and all extended codes → 0x00.

Overflow: `ps2_overflow`=1 on any cycle sets `err` and clears both pending flags. Only `rst` clears `err`.

Segment displays:
- Encoding is {a,b,c,d,e,f,g,dp}, active-low, dp always 1. Hex digits 0–F (e.g. '1' = 0x9F, '0' = 0x03).
- `seg_code_*` and `seg_ascii_*` show 0xFF (blank) while `key_down`=0.
- `seg_cnt_*` always show `press_cnt[7:0]`.
- Segments are decoded combinationally from the registered state.

## Timing
- Reset values:
  - state IDLE; `nextdata_n`=1;
  - `key_code`=0, `key_ext`=0, `key_ascii`=0, `key_down`=0, `press_cnt`=0;
  - `event_valid`=0, `event_break`=0, `err`=0;
  - `brk_pend`=0, `ext_pend`=0;
  - `seg_code_*`=`seg_ascii_*`=0xFF, `seg_cnt_*`=0x03.
- Edge N samples `ps2_ready`=1 in IDLE. After edge N: `nextdata_n`=0 for exactly one cycle. After edge N+1: outputs and `event_valid` update, `nextdata_n`=1.
- Earliest next sample is edge N+2, so throughput is one byte per 2 cycles.
- `rst` overrides everything on the same edge, including mid-ACK and mid-sequence. Pending F0/E0 are discarded.
- Overflow in the same cycle as an ACK decode: the decode of `byte_r` applies first, then the pending flags are cleared.

## Configuration
- **`KBD_SHIFT_EN` defined:**
  - track a `shift_held` flag from make/break of 0x12 and 0x59;
  - shift codes update only `shift_held`: no change to `key_code`/`press_cnt`, no `event_valid`;
  - letters map to 0x41–0x5A while `shift_held`=1.
- **`KBD_SHIFT_EN` undefined:** 0x12 and 0x59 decode as ordinary keys with ASCII 0x00.

## Test plan
- **Press and release q:** bytes 15, F0, 15.
  - After 15: `key_code`=0x15, `key_ascii`=0x71, `key_down`=1, `press_cnt`=1, `seg_code_hi`=0x9F.
  - After F0, 15: `key_down`=0, `press_cnt`=1, code/ASCII digits 0xFF.
- **Typematic repeat:** bytes 1C, 1C, 1C, F0, 1C → four `event_valid` pulses (last with `event_break`=1), `press_cnt`=1, `key_ascii`=0x61.
- **Extended key:** bytes E0, 75, F0, E0, 75 → `key_ext`=1, `key_code`=0x75, `key_ascii`=0x00, final `key_down`=0.
- **Handshake:** `ps2_ready` held high for 3 bytes → `nextdata_n` low exactly 1 cycle per byte, with at least 1 high cycle between pops.
- **Counter wrap and reset:**
  - 256 distinct presses → `press_cnt`=0x00.
  - `rst` asserted after F0 → next 15 decodes as a make with `press_cnt`=1.
- **Shift:** bytes 12, 1C, F0, 1C, F0, 12.
  - With `KBD_SHIFT_EN`: `key_ascii`=0x41, `press_cnt`=1.
  - Without it: `press_cnt`=2, `key_ascii`=0x61.
